// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back datapath.
//
// Captures MEM-stage results and builds the register-file write data, which
// is either the ALU result or the load word narrowed to a byte or half and
// sign- or zero-extended. The register-file write port is driven once per
// retiring instruction. A retired-instruction counter is also kept here.
//
// Ports:
//   clk                core clock; all state changes on the rising edge
//   rst                synchronous, active-high reset
//   stall              hold the MEM/WB register contents
//   flush              replace the incoming entry with a bubble (beats stall)
//   mem_valid          MEM stage holds a real instruction
//   mem_reg_write      instruction writes rd
//   mem_mem_to_reg     1 = load data, 0 = ALU result
//   mem_rd             destination register
//   mem_alu_result     ALU result / effective address
//   mem_load_data      raw aligned word from data memory
//   mem_load_size      00 byte, 01 half, 10/11 word
//   mem_load_unsigned  1 = zero-extend, 0 = sign-extend
//   rf_we              register-file write enable
//   rf_waddr           register-file write address (0 when no valid entry)
//   rf_wdata           register-file write data (0 when no valid entry)
//   wb_valid           WB stage holds a real instruction
//   retire_count       instructions retired since reset (wraps)
module wb_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_alu_result,
   input  logic [XLEN-1:0]       mem_load_data,
   input  logic [1:0]            mem_load_size,
   input  logic                  mem_load_unsigned,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  wb_valid,
   output logic [31:0]           retire_count
);

   logic                  valid;
   logic                  reg_write;
   logic                  mem_to_reg;
   logic [REG_ADDR_W-1:0] rd;
   logic [XLEN-1:0]       alu_result;
   logic [XLEN-1:0]       load_data;
   logic [1:0]            load_size;
   logic                  load_unsigned;
   logic [1:0]            byte_off;
   logic                  done;
   logic [31:0]           retire_cnt;

   logic                  fire;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [XLEN-1:0]       wdata_sel;

   // done marks an entry that has already written/retired while stalled, so
   // a held entry neither rewrites the register file nor counts twice.
   assign fire = valid & reg_write & (rd != '0) & ~done;

   always_comb begin
      load_byte = 8'h00;
      unique case (byte_off)
         2'd0: load_byte = load_data[7:0];
         2'd1: load_byte = load_data[15:8];
         2'd2: load_byte = load_data[23:16];
         2'd3: load_byte = load_data[31:24];
      endcase
      // byte_off[0] is ignored for halves; misaligned halves trap upstream.
      load_half = byte_off[1] ? load_data[31:16] : load_data[15:0];
   end

   always_comb begin
      wdata_sel = alu_result;
      if (mem_to_reg) begin
         unique case (load_size)
            2'b00:   wdata_sel = {{(XLEN-8){load_byte[7] & ~load_unsigned}}, load_byte};
            2'b01:   wdata_sel = {{(XLEN-16){load_half[15] & ~load_unsigned}}, load_half};
            default: wdata_sel = load_data;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid         <= 1'b0;
         reg_write     <= 1'b0;
         mem_to_reg    <= 1'b0;
         rd            <= '0;
         alu_result    <= '0;
         load_data     <= '0;
         load_size     <= 2'b00;
         load_unsigned <= 1'b0;
         byte_off      <= 2'b00;
         done          <= 1'b0;
         retire_cnt    <= 32'd0;
      end else begin
         if (flush) begin
            valid         <= 1'b0;
            reg_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            rd            <= '0;
            alu_result    <= '0;
            load_data     <= '0;
            load_size     <= 2'b00;
            load_unsigned <= 1'b0;
            byte_off      <= 2'b00;
            done          <= 1'b0;
         end else if (stall) begin
            // Set on the first stalled edge whether or not the entry writes,
            // because retirement counting keys off the same flag.
            done <= done | fire | valid;
         end else begin
            valid         <= mem_valid;
            reg_write     <= mem_reg_write;
            mem_to_reg    <= mem_mem_to_reg;
            rd            <= mem_rd;
            alu_result    <= mem_alu_result;
            load_data     <= mem_load_data;
            load_size     <= mem_load_size;
            load_unsigned <= mem_load_unsigned;
            byte_off      <= mem_alu_result[1:0];
            done          <= 1'b0;
         end
         // Counting is independent of capture: the entry in WB this cycle
         // retires even if the incoming one is flushed.
         if (valid && !done)
            retire_cnt <= retire_cnt + 32'd1;
      end
   end

   assign rf_we        = fire;
   assign rf_waddr     = valid ? rd : '0;
   assign rf_wdata     = valid ? wdata_sel : '0;
   assign wb_valid     = valid;
   assign retire_count = retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_reg_write = 1'b0;
   logic        mem_mem_to_reg = 1'b0;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_alu_result = '0;
   logic [31:0] mem_load_data = '0;
   logic [1:0]  mem_load_size = '0;
   logic        mem_load_unsigned = 1'b0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_valid;
   logic [31:0] retire_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_cnt = 32'd0;
   bit          mon_en = 1'b0;
   wr_t         exp_q[$];

   localparam logic [31:0] LD = 32'h80FF_7F01;

   wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_valid(wb_valid), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every register-file write the DUT presents must match the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got waddr=%0d wdata=0x%08h expected no write",
                        rf_waddr, rf_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
               check("wb_wdata", rf_wdata, e.data);
            end
         end
         if (!wb_valid) begin
            check("idle_we", {31'd0, rf_we}, 32'd0);
            check("idle_waddr", {27'd0, rf_waddr}, 32'd0);
            check("idle_wdata", rf_wdata, 32'd0);
         end
      end
   end

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] sz,
                        input logic uns, input logic st, input logic fl);
      mem_valid         = v;
      mem_reg_write     = rw;
      mem_mem_to_reg    = m2r;
      mem_rd            = rd;
      mem_alu_result    = alu;
      mem_load_data     = ld;
      mem_load_size     = sz;
      mem_load_unsigned = uns;
      stall             = st;
      flush             = fl;
      @(posedge clk);
      #1;
   endtask

   // Issue a real instruction that will be captured; expected write is
   // pushed before it reaches WB.
   task automatic entry(input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] sz,
                        input logic uns, input logic [31:0] exp_wdata);
      wr_t e;
      if (rw && rd != 5'd0) begin
         e.addr = rd;
         e.data = exp_wdata;
         exp_q.push_back(e);
      end
      exp_cnt = exp_cnt + 32'd1;
      drive(1'b1, rw, m2r, rd, alu, ld, sz, uns, 1'b0, 1'b0);
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held two edges with a real instruction on the MEM inputs.
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1111_1111, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0);
         check("rst_we", {31'd0, rf_we}, 32'd0);
         check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
         check("rst_count", retire_count, 32'd0);
      end
      rst = 1'b0;
      mon_en = 1'b1;

      // ALU writeback, captured at the first edge after release.
      entry(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'd0, 2'b10, 1'b0, 32'h1234_5678);
      check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("alu_we", {31'd0, rf_we}, 32'd1);
      bubble();
      check("alu_count", retire_count, 32'd1);

      // Loads from word 0x80FF_7F01, back to back.
      entry(1'b1, 1'b1, 5'd1, 32'h1000_0002, LD, 2'b00, 1'b0, 32'hFFFF_FFFF);
      entry(1'b1, 1'b1, 5'd2, 32'h1000_0002, LD, 2'b00, 1'b1, 32'h0000_00FF);
      entry(1'b1, 1'b1, 5'd3, 32'h1000_0002, LD, 2'b01, 1'b0, 32'hFFFF_80FF);
      entry(1'b1, 1'b1, 5'd4, 32'h1000_0000, LD, 2'b01, 1'b0, 32'h0000_7F01);
      entry(1'b1, 1'b1, 5'd6, 32'h1000_0003, LD, 2'b00, 1'b0, 32'hFFFF_FF80);
      entry(1'b1, 1'b1, 5'd8, 32'h1000_0000, LD, 2'b00, 1'b1, 32'h0000_0001);
      entry(1'b1, 1'b1, 5'd9, 32'h1000_0001, LD, 2'b00, 1'b0, 32'h0000_007F);
      entry(1'b1, 1'b1, 5'd10, 32'h1000_0002, LD, 2'b01, 1'b1, 32'h0000_80FF);
      entry(1'b1, 1'b1, 5'd11, 32'h1000_0003, LD, 2'b01, 1'b0, 32'hFFFF_80FF);
      entry(1'b1, 1'b1, 5'd12, 32'h1000_0000, LD, 2'b10, 1'b0, 32'h80FF_7F01);
      entry(1'b1, 1'b1, 5'd13, 32'h1000_0001, LD, 2'b11, 1'b1, 32'h80FF_7F01);
      bubble();
      check("load_count", retire_count, exp_cnt);

      // Stall: rd=7 writes only in its first WB cycle.
      entry(1'b1, 1'b0, 5'd7, 32'hCAFE_0007, 32'd0, 2'b10, 1'b0, 32'hCAFE_0007);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd14, 32'hDEAD_0000, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
         check("stall_we", {31'd0, rf_we}, 32'd0);
         check("stall_waddr", {27'd0, rf_waddr}, 32'd7);
         check("stall_wdata", rf_wdata, 32'hCAFE_0007);
         check("stall_count", retire_count, exp_cnt);
      end
      bubble();
      check("stall_count_after", retire_count, exp_cnt);

      // Flush beats stall: the incoming rd=15 entry becomes a bubble.
      entry(1'b1, 1'b0, 5'd16, 32'h0000_0016, 32'd0, 2'b10, 1'b0, 32'h0000_0016);
      drive(1'b1, 1'b1, 1'b0, 5'd15, 32'h0000_0015, 32'd0, 2'b10, 1'b0, 1'b1, 1'b1);
      check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("flush_we", {31'd0, rf_we}, 32'd0);
      check("flush_count", retire_count, exp_cnt);
      bubble();
      check("flush_count_after", retire_count, exp_cnt);

      // rd=0 retires and counts but never writes.
      entry(1'b1, 1'b0, 5'd0, 32'h0000_0BAD, 32'd0, 2'b10, 1'b0, 32'd0);
      check("rd0_we", {31'd0, rf_we}, 32'd0);
      check("rd0_wb_valid", {31'd0, wb_valid}, 32'd1);
      bubble();
      check("rd0_count", retire_count, exp_cnt);

      // Counter wrap from a backdoor-loaded all-ones value.
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      exp_cnt = 32'hFFFF_FFFF;
      entry(1'b1, 1'b0, 5'd17, 32'h0000_0017, 32'd0, 2'b10, 1'b0, 32'h0000_0017);
      check("wrap_before", retire_count, 32'hFFFF_FFFF);
      bubble();
      check("wrap_count", retire_count, 32'd0);
      exp_cnt = 32'd0;

      // Reset during a stall discards the entry and clears the counter.
      entry(1'b1, 1'b0, 5'd3, 32'h0000_0333, 32'd0, 2'b10, 1'b0, 32'h0000_0333);
      drive(1'b1, 1'b1, 1'b0, 5'd18, 32'h0000_0018, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 5'd18, 32'h0000_0018, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      exp_cnt = 32'd0;
      check("rst_stall_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_stall_count", retire_count, exp_cnt);
      bubble();
      bubble();
      check("final_count", retire_count, exp_cnt);
      check("pending_writes", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
